// File: rtl/ram_reader_pkg.sv
// Shared defaults, FSM state encoding and output-FIFO sizing for the RAM burst reader.
package ram_reader_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Two entries of slack beyond the read pipeline keep a full-rate stream bubble-free.
  function automatic int unsigned fifo_depth(input int unsigned rd_lat);
    return 2 + rd_lat;
  endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous output FIFO with count-based full/empty and async reset.
module ram_rd_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          din,
  input  logic                       pop,
  output logic [DATA_W-1:0]          dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ram_reader.sv
// Streams a burst of bytes from a RAM read port into a ready/valid output with credit flow control.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic              clka,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addra,
  output logic              ram_wea,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int unsigned DEPTH = fifo_depth(RD_LAT);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  state_t            state;
  state_t            state_next;
  logic              done_next;
  logic              issue;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              credit_ok;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] addr_hold;
  logic [ADDR_W:0]   len_reg;
  logic [ADDR_W:0]   issued;
  logic [RD_LAT-1:0] pipe;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fcount;

  assign ram_wea   = 1'b0;
  assign ram_dina  = '0;
  assign busy      = (state != IDLE);
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign push      = pipe[RD_LAT-1];
  assign credit_ok = ({1'b0, inflight} + {1'b0, fcount}) < (CNT_W+1)'(DEPTH);

  // Address is presented in the issue cycle itself so RAM latency lines up with the capture pipe.
  assign ram_addra = issue ? base_reg + issued[ADDR_W-1:0] : addr_hold;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    issue      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) done_next  = 1'b1;
          else              state_next = RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (issued + 1'b1 == len_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0 && fcount == CNT_W'(1) && pop) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      base_reg  <= '0;
      len_reg   <= '0;
      issued    <= '0;
      addr_hold <= '0;
      pipe      <= '0;
      inflight  <= '0;
    end else begin
      if (state == IDLE && start && length != '0) begin
        base_reg <= base_addr;
        len_reg  <= length;
        issued   <= '0;
      end else if (issue) begin
        issued <= issued + 1'b1;
      end
      addr_hold <= ram_addra;
      pipe[0]   <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
    end
  end

  ram_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clka),
    .rst   (rst),
    .push  (push),
    .din   (ram_douta),
    .pop   (pop),
    .dout  (m_data),
    .empty (fifo_empty),
    .count (fcount)
  );

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: RAM holds addr[7:0], transfers are logged at each rising edge.
module tb_ram_reader;

  logic       clka = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] base_addr;
  logic [9:0] length;
  logic       busy;
  logic       done;
  logic [8:0] ram_addra;
  logic       ram_wea;
  logic [7:0] ram_dina;
  logic [7:0] ram_douta;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [512];
  logic [7:0] xq[$];
  int         xc[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         acc_cyc = 0;
  int         vhigh = 0;
  int         stall_err = 0;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = '0;

  always #5 clka = ~clka;

  ram_reader #(
    .ADDR_W (9),
    .DATA_W (8),
    .RD_LAT (1)
  ) dut (
    .clka      (clka),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_addra (ram_addra),
    .ram_wea   (ram_wea),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
  end

  always @(posedge clka) ram_douta <= mem[ram_addra];

  always @(posedge clka) begin
    cyc <= cyc + 1;
    if (m_valid && m_ready) begin
      xq.push_back(m_data);
      xc.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (m_valid) vhigh <= vhigh + 1;
    if (start && !busy && !rst) acc_cyc <= cyc;
    if (!rst && pv && !pr && (!m_valid || m_data !== pd)) stall_err <= stall_err + 1;
    pv <= m_valid;
    pr <= m_ready;
    pd <= m_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [8:0] b, input logic [9:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(negedge clka);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clka);
      if (done_cnt != d0) break;
    end
    check(tag, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int n0;
    int d0;
    int v0;
    int bad;

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    repeat (3) @(negedge clka);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_valid", 32'(m_valid),   32'd0);
    check("rst_addr",  32'(ram_addra), 32'd0);
    check("rst_wea",   32'(ram_wea),   32'd0);
    check("rst_dina",  32'(ram_dina),  32'd0);
    rst = 1'b0;
    @(negedge clka);

    // base 0, len 16, full-rate stream
    n0 = xq.size(); d0 = done_cnt;
    go(9'h000, 10'd16);
    check("b16_busy", 32'(busy), 32'd1);
    wait_done("b16_done", d0, 100);
    repeat (2) @(negedge clka);
    check("b16_count", 32'(xq.size() - n0), 32'd16);
    for (int i = 0; i < 16; i++) check("b16_data", 32'(xq[n0+i]), 32'(i));
    check("b16_lat",   32'(xc[n0] - acc_cyc), 32'd3);
    check("b16_span",  32'(xc[n0+15] - xc[n0]), 32'd15);
    check("b16_dlat",  32'(done_cyc - xc[n0+15]), 32'd1);
    check("b16_once",  32'(done_cnt - d0), 32'd1);
    check("b16_idle",  32'(busy), 32'd0);

    // address wrap at the top of memory
    n0 = xq.size(); d0 = done_cnt;
    go(9'h1FE, 10'd4);
    wait_done("wrap_done", d0, 100);
    repeat (2) @(negedge clka);
    check("wrap_count", 32'(xq.size() - n0), 32'd4);
    check("wrap_d0", 32'(xq[n0+0]), 32'hFE);
    check("wrap_d1", 32'(xq[n0+1]), 32'hFF);
    check("wrap_d2", 32'(xq[n0+2]), 32'h00);
    check("wrap_d3", 32'(xq[n0+3]), 32'h01);
    check("wrap_hold", 32'(ram_addra), 32'h001);

    // back-pressure: m_ready alternates every cycle
    n0 = xq.size(); d0 = done_cnt;
    go(9'h005, 10'd10);
    for (int i = 0; i < 200; i++) begin
      m_ready = ~m_ready;
      @(negedge clka);
      if (done_cnt != d0) break;
    end
    m_ready = 1'b1;
    check("bp_done", 32'(done_cnt - d0), 32'd1);
    repeat (2) @(negedge clka);
    check("bp_count", 32'(xq.size() - n0), 32'd10);
    bad = 0;
    for (int i = 0; i < 10; i++) if (xq[n0+i] !== 8'(5 + i)) bad++;
    check("bp_order", 32'(bad), 32'd0);
    check("bp_stable", 32'(stall_err), 32'd0);

    // zero length: done next cycle, no output
    n0 = xq.size(); d0 = done_cnt; v0 = vhigh;
    go(9'h033, 10'd0);
    check("len0_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clka);
    check("len0_done", 32'(done_cnt - d0), 32'd1);
    check("len0_dlat", 32'(done_cyc - acc_cyc), 32'd1);
    check("len0_valid", 32'(vhigh - v0), 32'd0);

    // start while busy must be ignored
    n0 = xq.size(); d0 = done_cnt;
    go(9'h010, 10'd3);
    go(9'h040, 10'd5);
    wait_done("ign_done", d0, 100);
    repeat (10) @(negedge clka);
    check("ign_count", 32'(xq.size() - n0), 32'd3);
    check("ign_d0", 32'(xq[n0+0]), 32'h10);
    check("ign_d2", 32'(xq[n0+2]), 32'h12);
    check("ign_once", 32'(done_cnt - d0), 32'd1);

    // reset mid-burst, then a fresh burst
    n0 = xq.size(); d0 = done_cnt;
    go(9'h000, 10'd20);
    for (int i = 0; i < 50; i++) begin
      if (xq.size() >= n0 + 3) break;
      @(negedge clka);
    end
    check("mid_three", 32'(xq.size() - n0), 32'd3);
    rst = 1'b1;
    #1;
    check("mid_busy",  32'(busy),      32'd0);
    check("mid_valid", 32'(m_valid),   32'd0);
    check("mid_addr",  32'(ram_addra), 32'd0);
    @(negedge clka);
    check("mid_done0", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clka);
    check("mid_nodone", 32'(done_cnt - d0), 32'd0);
    check("mid_nomore", 32'(xq.size() - n0), 32'd3);
    n0 = xq.size();
    go(9'h000, 10'd2);
    wait_done("post_done", d0, 100);
    repeat (2) @(negedge clka);
    check("post_count", 32'(xq.size() - n0), 32'd2);
    check("post_d0", 32'(xq[n0+0]), 32'h00);
    check("post_d1", 32'(xq[n0+1]), 32'h01);

    // full memory sweep
    n0 = xq.size(); d0 = done_cnt;
    go(9'h000, 10'd512);
    wait_done("full_done", d0, 1000);
    repeat (5) @(negedge clka);
    check("full_count", 32'(xq.size() - n0), 32'd512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (xq[n0+i] !== 8'(i)) bad++;
    check("full_order", 32'(bad), 32'd0);
    check("full_span",  32'(xc[n0+511] - xc[n0]), 32'd511);
    check("full_once",  32'(done_cnt - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
